// File: rtl/uart_receiver_if.sv
// uart_receiver_if: host-side and serial-side signals of the UART receiver.
//   CLK16X        16x baud clock, sampled on CLK
//   SDI           serial data in, idle high
//   RDN           active-low read strobe
//   DOUT          received byte holding register
//   DATA_READY    DOUT holds an unread byte
//   FRAMING_ERROR stop bit of last frame sampled low
//   OVERRUN       a frame completed while DATA_READY was still set
// slave = receiver side, master = host/driver side.
interface uart_receiver_if;
  logic       CLK16X;
  logic       SDI;
  logic       RDN;
  logic [7:0] DOUT;
  logic       DATA_READY;
  logic       FRAMING_ERROR;
  logic       OVERRUN;

  modport slave  (input  CLK16X, SDI, RDN,
                  output DOUT, DATA_READY, FRAMING_ERROR, OVERRUN);
  modport master (output CLK16X, SDI, RDN,
                  input  DOUT, DATA_READY, FRAMING_ERROR, OVERRUN);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first UART receiver on a 16x oversampling tick.
// Ports:
//   CLK   system clock (rising edge)
//   RST_N async active-low reset
//   bus   uart_receiver_if.slave (CLK16X, SDI, RDN in; DOUT and status out)
// A frame is sampled mid-bit (8 ticks into start, then every 16 ticks).
// Completion loads DOUT and status; an RDN low cycle clears the status.
module uart_receiver #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic           CLK,
  input  logic           RST_N,
  uart_receiver_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_clk16x;
  logic [3:0]             r_tick_cnt, w_tick_nxt;
  logic [3:0]             r_bit_cnt, w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0]   r_dout;
  logic                   r_dr, r_fe, r_ov;
  logic                   w_tick, w_sdi_s, w_done;

  assign w_sdi_s = r_sync[SYNC_STAGES-1];
  assign w_tick  = bus.CLK16X & ~r_clk16x;

  // Synchronizer resets to idle-high so reset never fakes a start bit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync   <= '1;
      r_clk16x <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.SDI};
      r_clk16x <= bus.CLK16X;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_sdi_s) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
          end
        end
        S_START: begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd7) begin
            if (!w_sdi_s) begin
              w_state_nxt = S_DATA;
              w_tick_nxt  = '0;
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = S_IDLE;  // start bit did not hold: glitch
            end
          end
        end
        S_DATA: begin
          w_tick_nxt = r_tick_cnt + 4'd1;  // 4-bit wrap keeps 16-tick spacing
          if (r_tick_cnt == 4'd15) begin
            w_shift_nxt = {w_sdi_s, r_shift[DATA_BITS-1:1]};
            w_bit_nxt   = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'(DATA_BITS - 1)) w_state_nxt = S_STOP;
          end
        end
        S_STOP: begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            w_done      = 1'b1;
            // A low stop bit parks in BREAK until the line returns high.
            w_state_nxt = w_sdi_s ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          if (w_sdi_s) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Completion beats a same-cycle read; the read still cancels the
  // overrun, since the previous byte was consumed.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dout <= '0;
      r_dr   <= 1'b0;
      r_fe   <= 1'b0;
      r_ov   <= 1'b0;
    end else if (w_done) begin
      r_dout <= r_shift;
      r_dr   <= 1'b1;
      r_fe   <= ~w_sdi_s;
      r_ov   <= bus.RDN & (r_ov | r_dr);
    end else if (!bus.RDN) begin
      r_dr <= 1'b0;
      r_fe <= 1'b0;
      r_ov <= 1'b0;
    end
  end

  assign bus.DOUT          = 8'(r_dout);
  assign bus.DATA_READY    = r_dr;
  assign bus.FRAMING_ERROR = r_fe;
  assign bus.OVERRUN       = r_ov;

endmodule
